// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: control codes, funct
// field values, main-decoder op classes and FSM state encoding.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // ALU control codes
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  // R-type funct field values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // Main-decoder op classes
  localparam int OP_FUNC = 0;
  localparam int OP_ADD  = 1;
  localparam int OP_SUB  = 2;
  localparam int OP_AND  = 3;
  localparam int OP_OR   = 4;
  localparam int OP_SLT  = 5;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational decode of op class and funct field into an ALU
// control code plus mult/div and illegal-encoding flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [5:0]      func,
  input  logic [OP_W-1:0] inOp,
  output logic [3:0]      code,
  output logic            isMd,
  output logic            mdSel,
  output logic            illegal
);

  // Op-class decode, falling through to the funct field for R-type
  always_comb begin
    code    = CTL_AND;
    isMd    = 1'b0;
    mdSel   = 1'b0;
    illegal = 1'b0;
    case (inOp)
      OP_W'(OP_FUNC): begin
        case (func)
          FN_ADD:  code = CTL_ADD;
          FN_SUB:  code = CTL_SUB;
          FN_AND:  code = CTL_AND;
          FN_OR:   code = CTL_OR;
          FN_NOR:  code = CTL_NOR;
          FN_SLT:  code = CTL_SLT;
          FN_MULT: isMd = 1'b1;
          FN_DIV: begin
            isMd  = 1'b1;
            mdSel = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_W'(OP_ADD): code = CTL_ADD;
      OP_W'(OP_SUB): code = CTL_SUB;
      OP_W'(OP_AND): code = CTL_AND;
      OP_W'(OP_OR):  code = CTL_OR;
      OP_W'(OP_SLT): code = CTL_SLT;
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registers single-cycle ALU control codes and
// sequences multicycle MULT/DIV operations with a busy down-counter.
//
//   state | meaning
//   IDLE  | accepting; single-cycle ops complete here with latency 1
//   BUSY  | mult/div running; counter counts down to terminal
//   DONE  | one-cycle completion: HiLoWe and OutValid pulse
//
// The counter is loaded with N-1 on acceptance and BUSY exits as the count
// reaches zero, so MdStart..DONE inclusive spans exactly N Stall cycles.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W       = 3,
  parameter int CTL_W      = 4,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  input  logic [5:0]       Func,
  input  logic [OP_W-1:0]  InOp,
  input  logic             Flush,
  output logic [CTL_W-1:0] outOp,
  output logic             OutValid,
  output logic             Illegal,
  output logic             Stall,
  output logic             MdStart,
  output logic             MdSel,
  output logic             HiLoWe
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CTL_W-1:0] outOpNext;
  logic             validNext, illegalNext, mdStartNext, mdSelNext, hiLoWeNext;
  logic [3:0]       decCode;
  logic             decIsMd, decMdSel, decIllegal;

  alu_ctrl_decode #(.OP_W(OP_W)) uDecode (
    .func    (Func),
    .inOp    (InOp),
    .code    (decCode),
    .isMd    (decIsMd),
    .mdSel   (decMdSel),
    .illegal (decIllegal)
  );

  // Next-state, counter and next-output logic
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    outOpNext   = outOp;
    validNext   = 1'b0;
    illegalNext = 1'b0;
    mdStartNext = 1'b0;
    mdSelNext   = MdSel;
    hiLoWeNext  = 1'b0;
    case (state)
      IDLE: begin
        if (InValid && !Flush) begin
          if (decIllegal) begin
            outOpNext   = '1;
            validNext   = 1'b1;
            illegalNext = 1'b1;
          end else if (decIsMd) begin
            stateNext   = BUSY;
            cntNext     = decMdSel ? DIV_LOAD : MUL_LOAD;
            mdStartNext = 1'b1;
            mdSelNext   = decMdSel;
            outOpNext   = '0;
          end else begin
            outOpNext = CTL_W'(decCode);
            validNext = 1'b1;
          end
        end
      end
      BUSY: begin
        if (Flush) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            stateNext  = DONE;
            hiLoWeNext = 1'b1;
            validNext  = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      outOp    <= '0;
      OutValid <= 1'b0;
      Illegal  <= 1'b0;
      Stall    <= 1'b0;
      MdStart  <= 1'b0;
      MdSel    <= 1'b0;
      HiLoWe   <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      outOp    <= outOpNext;
      OutValid <= validNext;
      Illegal  <= illegalNext;
      Stall    <= (stateNext != IDLE);
      MdStart  <= mdStartNext;
      MdSel    <= mdSelNext;
      HiLoWe   <= hiLoWeNext;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq with short MULT (4) and DIV (5) latencies.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       InValid;
  logic [5:0] Func;
  logic [2:0] InOp;
  logic       Flush;
  logic [3:0] outOp;
  logic       OutValid, Illegal, Stall, MdStart, MdSel, HiLoWe;

  int errors = 0;
  int checks = 0;

  alu_control_seq #(
    .OP_W(3), .CTL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .Func     (Func),
    .InOp     (InOp),
    .Flush    (Flush),
    .outOp    (outOp),
    .OutValid (OutValid),
    .Illegal  (Illegal),
    .Stall    (Stall),
    .MdStart  (MdStart),
    .MdSel    (MdSel),
    .HiLoWe   (HiLoWe)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [2:0] op);
    InValid = v;
    Func    = f;
    InOp    = op;
  endtask

  // single-cycle op table: {Func, InOp, expected code}
  typedef struct {
    logic [5:0] f;
    logic [2:0] op;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[9];
  logic sawHiLo;

  initial begin
    vecs[0] = '{6'b000000, 3'b001, 4'b0010};
    vecs[1] = '{6'b000000, 3'b010, 4'b0110};
    vecs[2] = '{6'b000000, 3'b011, 4'b0000};
    vecs[3] = '{6'b000000, 3'b100, 4'b0001};
    vecs[4] = '{6'b000000, 3'b101, 4'b0111};
    vecs[5] = '{6'b100010, 3'b000, 4'b0110};
    vecs[6] = '{6'b100100, 3'b000, 4'b0000};
    vecs[7] = '{6'b100101, 3'b000, 4'b0001};
    vecs[8] = '{6'b100111, 3'b000, 4'b1100};

    rst = 1'b1;
    Flush = 1'b0;
    drive(1'b0, 6'd0, 3'd0);
    tick();
    tick();
    check_val("rst_outOp", outOp, 4'h0);
    check_val("rst_valid", OutValid, 0);
    check_val("rst_illegal", Illegal, 0);
    check_val("rst_stall", Stall, 0);
    check_val("rst_mdstart", MdStart, 0);
    check_val("rst_hilowe", HiLoWe, 0);
    rst = 1'b0;

    // ADD via funct
    drive(1'b1, 6'b100000, 3'b000);
    tick();
    check_val("add_outOp", outOp, 4'b0010);
    check_val("add_valid", OutValid, 1);
    check_val("add_stall", Stall, 0);

    // back-to-back SUB class then SLT funct
    drive(1'b1, 6'b000000, 3'b010);
    tick();
    check_val("b2b_sub", outOp, 4'b0110);
    check_val("b2b_sub_v", OutValid, 1);
    drive(1'b1, 6'b101010, 3'b000);
    tick();
    check_val("b2b_slt", outOp, 4'b0111);
    check_val("b2b_slt_v", OutValid, 1);

    // idle: outOp holds, valid drops
    drive(1'b0, 6'b100000, 3'b000);
    tick();
    check_val("idle_valid", OutValid, 0);
    check_val("idle_hold", outOp, 4'b0111);

    // remaining single-cycle encodings
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].f, vecs[i].op);
      tick();
      check_val($sformatf("tbl%0d_code", i), outOp, vecs[i].code);
      check_val($sformatf("tbl%0d_valid", i), OutValid, 1);
    end

    // illegal funct and illegal op class
    drive(1'b1, 6'b111011, 3'b000);
    tick();
    check_val("ill_fn_code", outOp, 4'hF);
    check_val("ill_fn_flag", Illegal, 1);
    check_val("ill_fn_valid", OutValid, 1);
    drive(1'b1, 6'b100000, 3'b110);
    tick();
    check_val("ill_op_flag", Illegal, 1);
    drive(1'b1, 6'b100000, 3'b000);
    tick();
    check_val("after_ill_flag", Illegal, 0);
    check_val("after_ill_code", outOp, 4'b0010);

    // Flush in IDLE suppresses acceptance
    drive(1'b1, 6'b000000, 3'b010);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check_val("idleflush_valid", OutValid, 0);
    check_val("idleflush_hold", outOp, 4'b0010);

    // MULT, 4 stall cycles, ADD presented during stall is ignored
    drive(1'b1, 6'b011000, 3'b000);
    tick();
    check_val("mul_mdstart", MdStart, 1);
    check_val("mul_mdsel", MdSel, 0);
    check_val("mul_outOp", outOp, 4'h0);
    check_val("mul_valid0", OutValid, 0);
    drive(1'b1, 6'b100000, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      check_val($sformatf("mul_stall_c%0d", c), Stall, 1);
      check_val($sformatf("mul_hilo_c%0d", c), HiLoWe, (c == 4) ? 1 : 0);
      check_val($sformatf("mul_valid_c%0d", c), OutValid, (c == 4) ? 1 : 0);
      if (c > 1) check_val($sformatf("mul_mdstart_c%0d", c), MdStart, 0);
      tick();
    end
    check_val("mul_end_stall", Stall, 0);
    check_val("mul_end_hilo", HiLoWe, 0);
    check_val("mul_end_valid", OutValid, 0);
    tick();
    check_val("mul_next_add", outOp, 4'b0010);
    check_val("mul_next_valid", OutValid, 1);

    // DIV full run: 5 stall cycles, HiLoWe on the 5th
    drive(1'b1, 6'b011010, 3'b000);
    tick();
    drive(1'b0, 6'b000000, 3'b000);
    check_val("div_mdsel", MdSel, 1);
    for (int c = 1; c <= 5; c++) begin
      check_val($sformatf("div_stall_c%0d", c), Stall, 1);
      check_val($sformatf("div_hilo_c%0d", c), HiLoWe, (c == 5) ? 1 : 0);
      tick();
    end
    check_val("div_end_stall", Stall, 0);

    // DIV flushed on the 2nd busy cycle
    drive(1'b1, 6'b011010, 3'b000);
    tick();
    drive(1'b0, 6'b000000, 3'b000);
    check_val("divf_mdstart", MdStart, 1);
    tick();
    check_val("divf_stall2", Stall, 1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check_val("divf_stall_drop", Stall, 0);
    check_val("divf_valid", OutValid, 0);
    sawHiLo = HiLoWe;
    for (int c = 0; c < 6; c++) begin
      tick();
      sawHiLo = sawHiLo | HiLoWe;
    end
    check_val("divf_no_hilo", sawHiLo, 0);

    // Flush coinciding with the terminal count (4th busy cycle of DIV)
    drive(1'b1, 6'b011010, 3'b000);
    tick();
    drive(1'b0, 6'b000000, 3'b000);
    tick();
    tick();
    tick();
    check_val("term_stall4", Stall, 1);
    check_val("term_hilo4", HiLoWe, 0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check_val("term_flush_hilo", HiLoWe, 0);
    check_val("term_flush_stall", Stall, 0);
    check_val("term_flush_valid", OutValid, 0);

    // async reset in the middle of a MULT busy period
    drive(1'b1, 6'b011000, 3'b000);
    tick();
    drive(1'b0, 6'b000000, 3'b000);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_stall", Stall, 0);
    check_val("arst_mdsel", MdSel, 0);
    check_val("arst_mdstart", MdStart, 0);
    check_val("arst_valid", OutValid, 0);
    check_val("arst_outOp", outOp, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 6'b100000, 3'b000);
    tick();
    check_val("arst_add", outOp, 4'b0010);
    check_val("arst_add_valid", OutValid, 1);
    drive(1'b0, 6'b000000, 3'b000);
    sawHiLo = HiLoWe;
    for (int c = 0; c < 5; c++) begin
      tick();
      sawHiLo = sawHiLo | HiLoWe | Stall;
    end
    check_val("arst_no_hilo", sawHiLo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- OP_W, 3, width of InOp.
- CTL_W, 4, width of outOp.
- MUL_CYCLES, 32, busy cycles for MULT (min 2).
- DIV_CYCLES, 32, busy cycles for DIV (min 2).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- InValid  in  1  Func/InOp qualified this cycle.
- Func  in  6  R-type funct field.
- InOp  in  OP_W  main-decoder ALU op class.
- Flush  in  1  synchronous abort of a multicycle op.
- outOp  out  CTL_W  registered ALU control code.
- OutValid  out  1  outOp/HiLoWe valid this cycle.
- Illegal  out  1  registered undefined Func/InOp flag.
- Stall  out  1  block busy; upstream holds instruction.
- MdStart  out  1  one-cycle start pulse to mult/div unit.
- MdSel  out  1  0 = MULT, 1 = DIV; held while busy.
- HiLoWe  out  1  one-cycle HI/LO write enable on completion.

Function
REQ-003 InOp decode SHALL be: 000 -> use Func; 001 -> ADD 0010; 010 -> SUB 0110; 011 -> AND 0000; 100 -> OR 0001; 101 -> SLT 0111; 110/111 -> Illegal.
REQ-004 Func decode (InOp=000) SHALL be: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100111 NOR 1100; 101010 SLT 0111; 011000 MULT; 011010 DIV; any other -> Illegal.
REQ-005 Illegal decode SHALL drive outOp=all-ones, Illegal=1, OutValid=1, one cycle after acceptance.
REQ-006 FSM states SHALL be IDLE, BUSY, DONE.
REQ-007 IDLE, InValid=1, single-cycle op: outOp registered, OutValid=1 next cycle (latency 1), FSM stays IDLE; back-to-back accepts every cycle.
REQ-008 IDLE, InValid=1, MULT/DIV: next cycle MdStart=1 (one cycle), MdSel set, Stall=1, counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1, FSM -> BUSY; outOp=0000, OutValid=0.
REQ-009 BUSY: counter decrements each cycle; at counter==0 FSM -> DONE.
REQ-010 DONE: HiLoWe=1 and OutValid=1 for exactly one cycle, Stall=1, then FSM -> IDLE with Stall=0.
REQ-011 Total busy length SHALL be exactly MUL_CYCLES (resp. DIV_CYCLES) cycles of Stall from the MdStart cycle through DONE inclusive.
REQ-012 InValid while Stall=1 SHALL be ignored (no decode, no state change).
REQ-013 Flush=1 in BUSY or DONE SHALL return FSM to IDLE next cycle with HiLoWe=0, OutValid=0, Stall=0; Flush in IDLE SHALL suppress acceptance that cycle.
REQ-014 Flush and counter==0 in the same cycle: Flush wins, no HiLoWe.
REQ-015 When not accepting, OutValid=0 and outOp holds its last value.

Reset
REQ-016 rst=1 SHALL asynchronously force FSM=IDLE, counter=0, outOp=0000, OutValid=0, Illegal=0, Stall=0, MdStart=0, MdSel=0, HiLoWe=0.
REQ-017 rst asserted mid-BUSY SHALL abort with no HiLoWe pulse after release; first edge after release may accept input.

Structure
REQ-018 ALU control codes, funct constants and FSM state encodings SHALL live in a shared package alu_ctrl_pkg.
REQ-019 Combinational decode SHALL be one sub-module alu_ctrl_decode (Func, InOp -> code, is_md, md_sel, illegal); alu_control_seq holds FSM, counter and output registers.
REQ-020 Counter width SHALL be $clog2(max(MUL_CYCLES, DIV_CYCLES)).

Verification
REQ-021 Func=100000, InOp=000, InValid=1 -> next cycle outOp=0010, OutValid=1, Stall=0.
REQ-022 Back-to-back InOp=010 then Func=101010/InOp=000 -> outOp 0110 then 0111 on consecutive cycles.
REQ-023 Func=011000, InOp=000, MUL_CYCLES=4 -> MdStart 1 cycle, MdSel=0, Stall 4 cycles, HiLoWe=1 on 4th, InValid during Stall ignored.
REQ-024 Func=111011, InOp=000 -> outOp=1111, Illegal=1, OutValid=1 next cycle.
REQ-025 DIV (Func=011010) with Flush on 2nd busy cycle -> Stall drops next cycle, HiLoWe never asserted.
REQ-026 rst asserted mid-BUSY between clock edges -> all outputs 0 immediately, IDLE; new ADD accepted after release.
